// File: rtl/packet_match_controller.sv
// Packet-match controller: sequences MAC packets through the comparator bank, scores weighted
// match flags against a threshold and keeps statistics. Define PMC_SATURATE_EN for saturating counters.
module packet_match_controller #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned COMP_LAT = 4,
    parameter int unsigned SCORE_W  = WEIGHT_W + $clog2(NUM_CH + 1)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       update_done,
    input  logic [NUM_CH*WEIGHT_W-1:0] cfg_weights,
    input  logic [SCORE_W-1:0]         cfg_threshold,
    input  logic                       clear_stats,
    input  logic                       sop,
    input  logic                       eop,
    input  logic                       valid,
    input  logic [5:0]                 error,
    input  logic [1:0]                 empty,
    input  logic [NUM_CH-1:0]          match,
    output logic                       ready,
    output logic                       inc_addr,
    output logic                       clear,
    output logic                       busy,
    output logic [NUM_CH*CNT_W-1:0]    hits,
    output logic [CNT_W-1:0]           pkt_count,
    output logic [CNT_W-1:0]           drop_count
);
    localparam int unsigned LAT_W = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;

    typedef enum logic [2:0] {
        CONFIG, IDLE, COMPARE, SETTLE, TALLY, STORE, DRAIN
    } state_t;

    state_t                     state, next_state;
    logic [NUM_CH*WEIGHT_W-1:0] weights;
    logic [SCORE_W-1:0]         threshold;
    logic [SCORE_W-1:0]         score_c;
    logic [LAT_W-1:0]           settle_cnt;
    logic                       err_c;
    logic                       ready_nxt, inc_addr_nxt, clear_nxt, busy_nxt;

    assign err_c = |error;

    // Weighted sum of asserted match flags at full score width
    always_comb begin
        score_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (match[i]) begin
                score_c = score_c + SCORE_W'(weights[i*WEIGHT_W +: WEIGHT_W]);
            end
        end
    end

    // Next-state and next-output decode
    always_comb begin
        next_state   = state;
        ready_nxt    = 1'b0;
        inc_addr_nxt = 1'b0;
        clear_nxt    = 1'b0;
        busy_nxt     = 1'b0;
        case (state)
            CONFIG:  if (update_done) next_state = IDLE;
            IDLE:    if (sop && valid) next_state = COMPARE;
            COMPARE: begin
                if (err_c) begin
                    next_state = eop ? IDLE : DRAIN;
                end else if (eop) begin
                    next_state = SETTLE;
                end
            end
            SETTLE:  if (settle_cnt == '0) next_state = TALLY;
            TALLY:   next_state = (score_c >= threshold) ? STORE : IDLE;
            STORE:   next_state = IDLE;
            DRAIN:   if (eop) next_state = IDLE;
            default: next_state = CONFIG;
        endcase
        busy_nxt = (next_state != CONFIG) && (next_state != IDLE);
        case (next_state)
            IDLE: begin
                ready_nxt = (empty != 2'd3);
                clear_nxt = 1'b1;
            end
            COMPARE, DRAIN: ready_nxt    = 1'b1;
            TALLY:          clear_nxt    = 1'b1;
            STORE:          inc_addr_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, configuration latch, settle timer and registered outputs
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= CONFIG;
            weights    <= '0;
            threshold  <= '0;
            settle_cnt <= '0;
            ready      <= 1'b0;
            inc_addr   <= 1'b0;
            clear      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state    <= next_state;
            ready    <= ready_nxt;
            inc_addr <= inc_addr_nxt;
            clear    <= clear_nxt;
            busy     <= busy_nxt;
            if (state == CONFIG && update_done) begin
                weights   <= cfg_weights;
                threshold <= cfg_threshold;
            end
            if (state == COMPARE && next_state == SETTLE) begin
                settle_cnt <= LAT_W'(COMP_LAT - 1);
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - LAT_W'(1);
            end
        end
    end

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PMC_SATURATE_EN
        return (&v) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    // Statistics; clear_stats overrides any same-cycle increment
    always_ff @(posedge clk) begin
        if (!n_rst || clear_stats) begin
            hits       <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (state == COMPARE && err_c) begin
                drop_count <= bump(drop_count);
            end
            if (state == TALLY) begin
                pkt_count <= bump(pkt_count);
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (match[i]) begin
                        hits[i*CNT_W +: CNT_W] <= bump(hits[i*CNT_W +: CNT_W]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_match_controller.sv
// Randomized scoreboard bench for packet_match_controller; CNT_W=4 so counter limits are reached quickly.
module tb_packet_match_controller;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 4;
    localparam int WEIGHT_W = 4;
    localparam int COMP_LAT = 4;
    localparam int SCORE_W  = WEIGHT_W + $clog2(NUM_CH + 1);
    localparam int WV_W     = NUM_CH * WEIGHT_W;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    n_rst, update_done, clear_stats, sop, eop, valid;
    logic [WV_W-1:0]         cfg_weights;
    logic [SCORE_W-1:0]      cfg_threshold;
    logic [5:0]              error;
    logic [1:0]              empty;
    logic [NUM_CH-1:0]       match;
    logic                    ready, inc_addr, clear, busy;
    logic [NUM_CH*CNT_W-1:0] hits;
    logic [CNT_W-1:0]        pkt_count, drop_count;

    packet_match_controller #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WEIGHT_W(WEIGHT_W), .COMP_LAT(COMP_LAT)
    ) dut (
        .clk(clk), .n_rst(n_rst), .update_done(update_done), .cfg_weights(cfg_weights),
        .cfg_threshold(cfg_threshold), .clear_stats(clear_stats), .sop(sop), .eop(eop),
        .valid(valid), .error(error), .empty(empty), .match(match), .ready(ready),
        .inc_addr(inc_addr), .clear(clear), .busy(busy), .hits(hits),
        .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                    store;
        logic [CNT_W-1:0]        pkt;
        logic [CNT_W-1:0]        drop;
        logic [NUM_CH*CNT_W-1:0] hits;
    } tally_t;

    tally_t tally_q[$];
    int     drop_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference model: configuration and statistics as plain integers
    int w_m [NUM_CH];
    int thr_m;
    int hits_m [NUM_CH];
    int pkt_m, drop_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bump_m(input int v);
`ifdef PMC_SATURATE_EN
        return (v >= CMAX) ? CMAX : v + 1;
`else
        return (v + 1) % (CMAX + 1);
`endif
    endfunction

    task automatic zero_model();
        pkt_m  = 0;
        drop_m = 0;
        for (int i = 0; i < NUM_CH; i++) hits_m[i] = 0;
    endtask

    task automatic model_tally(input logic [NUM_CH-1:0] m, input bit clr);
        tally_t e;
        int     score = 0;
        for (int i = 0; i < NUM_CH; i++) if (m[i]) score += w_m[i];
        e.store = (score >= thr_m);
        if (clr) begin
            zero_model();
        end else begin
            pkt_m = bump_m(pkt_m);
            for (int i = 0; i < NUM_CH; i++) if (m[i]) hits_m[i] = bump_m(hits_m[i]);
        end
        e.pkt  = CNT_W'(pkt_m);
        e.drop = CNT_W'(drop_m);
        for (int i = 0; i < NUM_CH; i++) e.hits[i*CNT_W +: CNT_W] = CNT_W'(hits_m[i]);
        tally_q.push_back(e);
    endtask

    // Monitor: pops expected tallies/drops whenever the DUT shows one
    bit               mon_en = 1'b0;
    bit               pending = 1'b0;
    bit               rst_d = 1'b1;
    bit               cs_d = 1'b0;
    int               settle_run = 0;
    logic [CNT_W-1:0] prev_drop = '0;
    tally_t           cur;

    always @(posedge clk) begin
        rst_d <= !n_rst;
        cs_d  <= clear_stats;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_d) begin
                pending    = 1'b0;
                settle_run = 0;
                prev_drop  = drop_count;
            end else begin
                if (pending) begin
                    chk("tally_inc_addr", inc_addr, cur.store);
                    chk("tally_pkt_count", pkt_count, cur.pkt);
                    chk("tally_hits", hits, cur.hits);
                    chk("tally_drop_count", drop_count, cur.drop);
                    pending = 1'b0;
                end else if (inc_addr) begin
                    chk("spurious_inc_addr", inc_addr, 1'b0);
                end
                if (cs_d) begin
                    prev_drop = drop_count;
                end else if (drop_count !== prev_drop) begin
                    if (drop_q.size() == 0) chk("unexpected_drop", drop_count, prev_drop);
                    else chk("drop_count", drop_count, drop_q.pop_front());
                    prev_drop = drop_count;
                end
                if (busy && clear) begin
                    chk("settle_cycles", settle_run, COMP_LAT);
                    settle_run = 0;
                    if (tally_q.size() == 0) begin
                        chk("unexpected_tally", clear, 1'b0);
                    end else begin
                        cur     = tally_q.pop_front();
                        pending = 1'b1;
                    end
                end else if (busy && !ready && !clear && !inc_addr) begin
                    settle_run++;
                end else begin
                    settle_run = 0;
                end
            end
        end
    end

    task automatic configure(input logic [WV_W-1:0] wv, input logic [SCORE_W-1:0] th);
        cfg_weights   = wv;
        cfg_threshold = th;
        update_done   = 1'b1;
        for (int i = 0; i < NUM_CH; i++) w_m[i] = int'(wv[i*WEIGHT_W +: WEIGHT_W]);
        thr_m = int'(th);
        @(negedge clk);
        update_done   = 1'b0;
        cfg_weights   = WV_W'($urandom);
        cfg_threshold = SCORE_W'($urandom);
    endtask

    // err_mode: 0 clean, 1 error mid-packet at err_beat, 2 error on the eop beat
    task automatic send_pkt(input logic [NUM_CH-1:0] m, input int nb, input int err_mode,
                            input int err_beat, input bit clr_tally, input bit abort);
        if (err_mode != 0) begin
            int old = drop_m;
            drop_m = bump_m(drop_m);
            if (drop_m != old) drop_q.push_back(drop_m);
        end else if (!abort) begin
            model_tally(m, clr_tally);
        end
        sop = 1'b1; valid = 1'b1; eop = 1'b0; error = '0; match = m;
        for (int b = 1; b <= nb; b++) begin
            @(negedge clk);
            sop = 1'b0; valid = 1'b1; eop = (b == nb); error = '0;
            if (err_mode == 1 && b == err_beat) error = 6'h01;
            else if (err_mode == 1 && b > err_beat) error = 6'($urandom);
            else if (err_mode == 2 && b == nb) error = 6'($urandom_range(1, 63));
        end
        @(negedge clk);
        sop = 1'b0; eop = 1'b0; valid = 1'b0; error = '0;
        if (err_mode != 0) begin
            match = '0;
        end else if (abort) begin
            @(negedge clk);
            n_rst = 1'b0;
            repeat (2) @(negedge clk);
            zero_model();
            chk("abort_ready", ready, 1'b0);
            chk("abort_inc_addr", inc_addr, 1'b0);
            chk("abort_clear", clear, 1'b0);
            chk("abort_busy", busy, 1'b0);
            chk("abort_pkt_count", pkt_count, CNT_W'(pkt_m));
            chk("abort_drop_count", drop_count, CNT_W'(drop_m));
            chk("abort_hits", hits, '0);
            n_rst = 1'b1;
            match = '0;
        end else begin
            repeat (COMP_LAT) @(negedge clk);
            if (clr_tally) clear_stats = 1'b1;
            @(negedge clk);
            clear_stats = 1'b0;
            match = '0;
        end
    endtask

    task automatic gap();
        repeat (1 + $urandom_range(0, 3)) begin
            case ($urandom_range(0, 3))
                0:       begin sop = 1'b1; valid = 1'b0; eop = 1'b0; end
                1:       begin sop = 1'b0; valid = 1'b0; eop = 1'b1; end
                default: begin sop = 1'b0; valid = 1'b0; eop = 1'b0; end
            endcase
            empty = 2'($urandom);
            @(negedge clk);
        end
        sop = 1'b0; eop = 1'b0; valid = 1'b0; empty = 2'd0;
    endtask

    task automatic random_pkt();
        int nb = $urandom_range(2, 5);
        int r  = $urandom_range(0, 9);
        int em = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
        send_pkt(NUM_CH'($urandom), nb, em, $urandom_range(1, nb - 1), 1'b0, 1'b0);
        gap();
    endtask

    initial begin
        n_rst = 1'b0; update_done = 1'b0; clear_stats = 1'b0; sop = 1'b0; eop = 1'b0;
        valid = 1'b0; error = '0; empty = '0; match = '0;
        cfg_weights = '0; cfg_threshold = '0;
        zero_model();
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1'b0);
        chk("rst_inc_addr", inc_addr, 1'b0);
        chk("rst_clear", clear, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hits", hits, '0);
        chk("rst_pkt_count", pkt_count, '0);
        chk("rst_drop_count", drop_count, '0);
        n_rst  = 1'b1;
        mon_en = 1'b1;
        sop = 1'b1; valid = 1'b1;
        repeat (2) @(negedge clk);
        sop = 1'b0; valid = 1'b0;
        chk("config_hold_clear", clear, 1'b0);
        chk("config_hold_busy", busy, 1'b0);

        configure({4'd4, 4'd1, 4'd2, 4'd2}, SCORE_W'(4));
        chk("idle_ready", ready, 1'b1);
        chk("idle_clear", clear, 1'b1);
        chk("idle_busy", busy, 1'b0);
        empty = 2'd3;
        @(negedge clk);
        chk("idle_ready_full", ready, 1'b0);
        empty = 2'd0;
        @(negedge clk);
        chk("idle_ready_back", ready, 1'b1);

        send_pkt(4'b0011, 3, 0, 0, 1'b0, 1'b0); gap();
        send_pkt(4'b0100, 2, 0, 0, 1'b0, 1'b0); gap();
        send_pkt(4'b1010, 4, 1, 2, 1'b0, 1'b0); gap();
        send_pkt(4'b0001, 3, 2, 0, 1'b0, 1'b0); gap();

        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        zero_model();
        chk("clear_pkt_count", pkt_count, CNT_W'(pkt_m));
        chk("clear_drop_count", drop_count, CNT_W'(drop_m));
        chk("clear_hits", hits, '0);
        repeat (17) begin
            send_pkt(4'b0001, 2, 0, 0, 1'b0, 1'b0);
            gap();
        end
        send_pkt(4'b1111, 2, 0, 0, 1'b1, 1'b0); gap();

        repeat (20) random_pkt();

        send_pkt(NUM_CH'($urandom), 2, 0, 0, 1'b0, 1'b1);
        configure(WV_W'($urandom), SCORE_W'(0));
        repeat (10) random_pkt();

        send_pkt(4'b1111, 3, 0, 0, 1'b0, 1'b1);
        configure(WV_W'($urandom), SCORE_W'($urandom_range(0, 4 * 15)));
        repeat (20) random_pkt();

        repeat (5) @(negedge clk);
        chk("tally_queue_left", tally_q.size(), 0);
        chk("drop_queue_left", drop_q.size(), 0);
        chk("tally_pending_left", pending, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
